spi_master_seq: RTL and testbench
=================================

Name: spi_master_seq

Overview:
- Host-side SPI master sequencer for register access to the team's SPI slave protocol block.
- Turns one host request (read or write, address, write data) into the two-frame SPI transaction the slave expects:
  - frame 1: command word {rnw, address}
  - frame 2: data word, written by the master or read back from the slave.
- Sits between a local bus master and the SPI pins; generates ss, sclk and mosi, and samples miso.

Parameters:
- DATA_W, 32: SPI frame width; also the width of the data and command words.
- ADDR_W, 16: address width. Must be < DATA_W; the rnw flag occupies bit ADDR_W.
- CLK_DIV, 4: sclk half-period in clk cycles; >= 1.
- GAP_CYC, 4: ss-high cycles after each frame; >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- req  in  1  request strobe; sampled only when ready=1
- rnw  in  1  1 = read, 0 = write
- addr  in  ADDR_W  target register address
- wdata  in  DATA_W  write data
- ready  out  1  idle, able to accept a request
- done  out  1  one-cycle pulse at transaction end
- rdata  out  DATA_W  read data; valid when done=1 and the transaction was a read
- err  out  1  verify mismatch flag (see Optional Feature)
- ss  out  1  slave select, active low
- sclk  out  1  SPI clock
- mosi  out  1  master out
- miso  in  1  master in

Behaviour:
- Reset values: ready=1, done=0, rdata=0, err=0, ss=1, sclk=0, mosi=0; state=IDLE.
- Asynchronous reset mid-transaction: ss goes high immediately; no done pulse; the latched request is discarded.
- SPI mode 0: sclk idles low; mosi changes on sclk falling edges and at ss fall; miso is sampled on sclk rising edges; MSB first.
- Handshake:
  - Accept cycle T is any cycle with req=1 and ready=1. rnw, addr and wdata are latched at T; ready=0 from T+1.
  - req while ready=0 is ignored; there is no queuing.
- Command word = zero-extended {rnw, addr}: bits [ADDR_W-1:0]=addr, bit ADDR_W=rnw, all higher bits 0.
- Frame timing, with F = (2*DATA_W+1)*CLK_DIV cycles:
  - ss falls with the MSB already on mosi.
  - DATA_W sclk periods follow, each CLK_DIV cycles low then CLK_DIV cycles high.
  - A final CLK_DIV-cycle low phase follows, then ss rises.
  - ss is low for exactly F cycles.
- States:
  - IDLE: ready=1. Accept → CMD, with ss low at T+1.
  - CMD: shift out the command word → GAP1.
  - GAP1: ss high for GAP_CYC cycles → DATA.
  - DATA: write shifts out wdata; read drives mosi=0 and shifts miso into the shift register → GAP2.
  - GAP2: ss high for GAP_CYC cycles → DONE.
  - DONE: for one cycle, done=1 and ready=1; read loads rdata → IDLE.
- Latency: done is asserted at T + 2F + 2*GAP_CYC + 1.
- A req in the DONE cycle is accepted; the next ss fall is then at least GAP_CYC+1 cycles after the previous ss rise.
- rdata holds its value until the next read completes. Writes leave rdata unchanged.
- Counters:
  - Bit counter: wraps 0..DATA_W-1.
  - Divider counter: wraps 0..CLK_DIV-1.
  - Neither counter runs in IDLE.

Optional Feature:
- Macro: SPI_MASTER_SEQ_WR_VERIFY_EN.
- Defined:
  - After GAP2 of a write, the block issues a read transaction to the same address: CMD with rnw=1, GAP1, DATA, GAP2.
  - In the DONE cycle it compares the read-back word with wdata; err = 1 on mismatch, 0 on match.
  - Write latency = 4F + 4*GAP_CYC + 1.
  - rdata is loaded with the read-back word.
  - err updates only in write-DONE cycles and otherwise holds.
- Undefined: err is constant 0; write latency is as in Behaviour.

Test Plan (DATA_W=32, ADDR_W=16, CLK_DIV=2, GAP_CYC=3, F=130):
1. Assert rst mid-idle and release → ready=1, ss=1, sclk=0, mosi=0, done=0, rdata=0, err=0.
2. Write addr=0x0012, wdata=0xDEADBEEF at cycle T:
   - slave model captures 0x00000012 then 0xDEADBEEF;
   - ss low T+1..T+130 and T+134..T+263;
   - done at T+267.
3. Read addr=0x0034, slave model drives 0xA5A50F0F on miso:
   - frame 1 = 0x00010034;
   - frame-2 mosi all 0;
   - rdata=0xA5A50F0F at done; rdata unchanged by a later write.
4. Second req held high from T+5 → ignored until ready. Accepted in the DONE cycle; its ss falls 4 cycles after the previous ss rise.
5. rst pulsed during DATA of a write → ss=1 in the same cycle; no done; the slave model sees no second-frame capture. The next request proceeds normally.
6. With SPI_MASTER_SEQ_WR_VERIFY_EN, write 0x11112222:
   - model reads back 0x11112223 → err=1 at done (cycle T+533);
   - matching read-back on a second write → err=0.

Source files
------------

// File: rtl/spi_master_seq.sv
// SPI master sequencer: one host request becomes a command frame plus a data frame (SPI mode 0).
// Optional macro SPI_MASTER_SEQ_WR_VERIFY_EN: each write is followed by a read-back of the
// same address, and err reports whether the read-back word differs from the written data.
module spi_master_seq #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned GAP_CYC = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              rnw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              done,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              ss,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = (DATA_W > 1)  ? $clog2(DATA_W)  : 1;
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_GAP1, S_DATA, S_GAP2, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic              sclk_q, sclk_d;
   logic              tail_q, tail_d;
   logic              ss_q, ss_d;
   logic              mosi_q, mosi_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              rnw_q, rnw_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              vphase_q, vphase_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              ready_q, ready_d;
   logic              done_q, done_d;

   logic              rd_c;
   logic              start_c;
   logic [DATA_W-1:0] frame_word_c;

   // Command word: zero-extended {rnw, addr}
   function automatic logic [DATA_W-1:0] cmd_word(input logic r, input logic [ADDR_W-1:0] a);
      return DATA_W'({r, a});
   endfunction

   // Next-state, frame sequencing and output computation
   always_comb begin
      state_d      = state_q;
      div_cnt_d    = div_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      sclk_d       = sclk_q;
      tail_d       = tail_q;
      ss_d         = ss_q;
      mosi_d       = mosi_q;
      shreg_d      = shreg_q;
      rnw_d        = rnw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      vphase_d     = vphase_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      start_c      = 1'b0;
      frame_word_c = '0;
      rd_c         = rnw_q | vphase_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (req) begin
               rnw_d        = rnw;
               addr_d       = addr;
               wdata_d      = wdata;
               vphase_d     = 1'b0;
               start_c      = 1'b1;
               frame_word_c = cmd_word(rnw, addr);
               state_d      = S_CMD;
            end
         end
         S_CMD, S_DATA: begin
            if (div_cnt_q == DIV_LAST) begin
               div_cnt_d = '0;
               if (!sclk_q) begin
                  if (tail_q) begin
                     // final low phase complete: end of frame
                     ss_d      = 1'b1;
                     tail_d    = 1'b0;
                     gap_cnt_d = '0;
                     state_d   = (state_q == S_CMD) ? S_GAP1 : S_GAP2;
                  end else begin
                     sclk_d  = 1'b1;
                     shreg_d = {shreg_q[DATA_W-2:0], miso};
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d = '0;
                     tail_d    = 1'b1;
                     mosi_d    = 1'b0;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     mosi_d    = (state_q == S_DATA && rd_c) ? 1'b0 : shreg_q[DATA_W-1];
                  end
               end
            end else begin
               div_cnt_d = div_cnt_q + DIV_W'(1);
            end
         end
         S_GAP1: begin
            if (gap_cnt_q == GAP_LAST) begin
               start_c      = 1'b1;
               frame_word_c = rd_c ? '0 : wdata_q;
               state_d      = S_DATA;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         S_GAP2: begin
            if (gap_cnt_q == GAP_LAST) begin
`ifdef SPI_MASTER_SEQ_WR_VERIFY_EN
               if (!rnw_q && !vphase_q) begin
                  // write done: read the same address back
                  vphase_d     = 1'b1;
                  start_c      = 1'b1;
                  frame_word_c = cmd_word(1'b1, addr_q);
                  state_d      = S_CMD;
               end else begin
                  state_d = S_DONE;
                  rdata_d = shreg_q;
                  if (!rnw_q) err_d = (shreg_q != wdata_q);
               end
`else
               state_d = S_DONE;
               if (rnw_q) rdata_d = shreg_q;
`endif
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Frame start: ss falls with the MSB already on mosi
      if (start_c) begin
         ss_d      = 1'b0;
         sclk_d    = 1'b0;
         tail_d    = 1'b0;
         div_cnt_d = '0;
         bit_cnt_d = '0;
         shreg_d   = frame_word_c;
         mosi_d    = frame_word_c[DATA_W-1];
      end

      ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
      done_d  = (state_d == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         sclk_q    <= 1'b0;
         tail_q    <= 1'b0;
         ss_q      <= 1'b1;
         mosi_q    <= 1'b0;
         shreg_q   <= '0;
         rnw_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         vphase_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sclk_q    <= sclk_d;
         tail_q    <= tail_d;
         ss_q      <= ss_d;
         mosi_q    <= mosi_d;
         shreg_q   <= shreg_d;
         rnw_q     <= rnw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         vphase_q  <= vphase_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign ready = ready_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign err   = err_q;
   assign ss    = ss_q;
   assign sclk  = sclk_q;
   assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_master_seq.sv
// Testbench for spi_master_seq: SPI slave register model plus transaction-level scoreboard.
// Builds with or without SPI_MASTER_SEQ_WR_VERIFY_EN; expectations follow the macro.
module tb_spi_master_seq;

   localparam int DW = 32;
   localparam int AW = 16;
   localparam int CD = 2;
   localparam int GC = 3;
   localparam int F  = (2*DW + 1) * CD;
`ifdef SPI_MASTER_SEQ_WR_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, req, rnw, miso = 1'b0;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata, rdata;
   logic          ready, done, err, ss, sclk, mosi;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   spi_master_seq #(.DATA_W(DW), .ADDR_W(AW), .CLK_DIV(CD), .GAP_CYC(GC)) dut (
      .clk(clk), .rst(rst), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .rdata(rdata), .err(err),
      .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // ss edge timestamps in cycle numbers (cycle n = interval after posedge n)
   int   fall_q[$];
   int   rise_q[$];
   logic ss_prev = 1'b1;
   always @(negedge clk) begin
      if (ss_prev === 1'b1 && ss === 1'b0) fall_q.push_back(cyc);
      if (ss_prev === 1'b0 && ss === 1'b1) rise_q.push_back(cyc);
      ss_prev <= ss;
   end

   // SPI slave: frame 1 = {rnw, addr}, frame 2 = data; incomplete frames abort the transaction
   logic [DW-1:0] sl_mem [0:255];
   logic [DW-1:0] sl_rx, sl_tx;
   logic [DW-1:0] frames_q[$];
   logic [AW-1:0] sl_addr = '0;
   int            sl_bits = 0;
   bit            sl_phase = 1'b0, sl_rd = 1'b0, corrupt = 1'b0;
   logic          ss_m = 1'b1, sclk_m = 1'b0;
   always @(ss or sclk) begin
      if (ss_m === 1'b1 && ss === 1'b0) begin
         sl_bits = 0;
         sl_rx   = '0;
         sl_tx   = (sl_phase && sl_rd) ? (sl_mem[sl_addr[7:0]] ^ DW'(corrupt)) : DW'($urandom);
         miso    = sl_tx[DW-1];
      end else if (ss_m === 1'b0 && ss === 1'b1) begin
         if (sl_bits == DW) begin
            frames_q.push_back(sl_rx);
            if (!sl_phase) begin
               sl_rd    = sl_rx[AW];
               sl_addr  = sl_rx[AW-1:0];
               sl_phase = 1'b1;
            end else begin
               if (!sl_rd) sl_mem[sl_addr[7:0]] = sl_rx;
               sl_phase = 1'b0;
            end
         end else begin
            sl_phase = 1'b0;
         end
         sl_bits = 0;
      end else if (ss === 1'b0 && sclk_m === 1'b0 && sclk === 1'b1) begin
         sl_rx   = {sl_rx[DW-2:0], mosi};
         sl_bits = sl_bits + 1;
      end else if (ss === 1'b0 && sclk_m === 1'b1 && sclk === 1'b0) begin
         sl_tx = {sl_tx[DW-2:0], 1'b0};
         miso  = sl_tx[DW-1];
      end
      ss_m   = ss;
      sclk_m = sclk;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [0:255];
   logic [DW-1:0] model_rdata = '0;
   logic          model_err = 1'b0;
   int            last_rise = 0;

   // Present a request and wait (bounded) for acceptance; t = accept cycle
   task automatic start_req(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output int t);
      int n = 0;
      rnw = r; addr = a; wdata = d; req = 1'b1;
      while (ready !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 64'(n < 5000), 64'(1));
      t = cyc;
   endtask

   // Follow an accepted transaction to done and score it; optionally raise a new req at t+5
   task automatic check_txn(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int t, input bit b2b,
                            input bit nb_en, input bit nb_r, input logic [AW-1:0] nb_a,
                            input logic [DW-1:0] nb_d, output int dc);
      int n = 0;
      int np = (!r && VERIFY) ? 2 : 1;
      int f, rs;
      logic [DW-1:0] exp_fr [4];
      @(negedge clk);
      req = 1'b0;
      chk("busy_ready", 64'(ready), 64'(0));
      chk("ss_low_t1", 64'(ss), 64'(0));
      chk("done_low_t1", 64'(done), 64'(0));
      while (done !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
         if (nb_en && cyc == t + 5) begin
            req = 1'b1; rnw = nb_r; addr = nb_a; wdata = nb_d;
         end
      end
      chk("done_timeout", 64'(n < 5000), 64'(1));
      dc = cyc;
      chk("latency", 64'(dc - t), 64'(np * 2 * (F + GC) + 1));
      chk("ready_at_done", 64'(ready), 64'(1));

      if (!r) ref_mem[a[7:0]] = d;
      exp_fr[0] = DW'({r, a});
      exp_fr[1] = r ? '0 : d;
      exp_fr[2] = DW'({1'b1, a});
      exp_fr[3] = '0;
      if (r) model_rdata = ref_mem[a[7:0]] ^ DW'(corrupt);
      if (!r && VERIFY) begin
         model_rdata = d ^ DW'(corrupt);
         model_err   = corrupt;
      end

      chk("frame_count", 64'(frames_q.size()), 64'(2 * np));
      for (int k = 0; k < 2 * np; k++) begin
         f  = (fall_q.size() > 0) ? fall_q.pop_front() : -1;
         rs = (rise_q.size() > 0) ? rise_q.pop_front() : -1;
         chk("ss_fall", 64'(f), 64'(t + 1 + k * (F + GC)));
         chk("ss_low_len", 64'(rs - f), 64'(F));
         if (k == 0 && b2b) chk("b2b_gap", 64'(f - last_rise), 64'(GC + 1));
         if (frames_q.size() > 0) chk("frame_word", 64'(frames_q.pop_front()), 64'(exp_fr[k]));
         last_rise = rs;
      end
      chk("rdata", 64'(rdata), 64'(model_rdata));
      chk("err", 64'(err), 64'(model_err));
      chk("sclk_idle", 64'(sclk), 64'(0));
   endtask

   initial begin
      int t, dc, tr, n_done;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      bit r;
      rst = 1'b1; req = 1'b0; rnw = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 256; i++) begin
         sl_mem[i]  = DW'($urandom);
         ref_mem[i] = sl_mem[i];
      end
      sl_mem[8'h34]  = 32'hA5A50F0F;
      ref_mem[8'h34] = 32'hA5A50F0F;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // reset state
      chk("rst_ready", 64'(ready), 64'(1));
      chk("rst_ss", 64'(ss), 64'(1));
      chk("rst_sclk", 64'(sclk), 64'(0));
      chk("rst_mosi", 64'(mosi), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      chk("rst_err", 64'(err), 64'(0));

      // directed write then read, read data held across a later write
      start_req(1'b0, 16'h0012, 32'hDEADBEEF, t);
      check_txn(1'b0, 16'h0012, 32'hDEADBEEF, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);
      start_req(1'b1, 16'h0034, 32'h0, t);
      check_txn(1'b1, 16'h0034, 32'h0, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);
      chk("read_A5", 64'(rdata), 64'(32'hA5A50F0F));
      d = DW'($urandom);
      start_req(1'b0, 16'h0035, d, t);
      check_txn(1'b0, 16'h0035, d, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);

      // req held during a busy transaction, accepted in the DONE cycle
      d = DW'($urandom);
      start_req(1'b0, 16'h0040, d, t);
      check_txn(1'b0, 16'h0040, d, t, 1'b0, 1'b1, 1'b1, 16'h0040, '0, dc);
      chk("held_req_accept", 64'(req & ready), 64'(1));
      check_txn(1'b1, 16'h0040, '0, dc, 1'b1, 1'b0, 1'b0, '0, '0, dc);

      // reset pulse during the data frame of a write
      d = DW'($urandom);
      start_req(1'b0, 16'h0050, d, t);
      @(negedge clk);
      req = 1'b0;
      while (cyc < t + F + GC + 20) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_ss", 64'(ss), 64'(1));
      chk("midrst_ready", 64'(ready), 64'(1));
      chk("midrst_rdata", 64'(rdata), 64'(0));
      model_rdata = '0;
      model_err   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      repeat (300) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      chk("midrst_no_done", 64'(n_done), 64'(0));
      chk("midrst_frames", 64'(frames_q.size()), 64'(1));
      frames_q.delete();
      fall_q.delete();
      rise_q.delete();
      start_req(1'b1, 16'h0050, '0, t);
      check_txn(1'b1, 16'h0050, '0, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);

      // write with corrupted read-back, then a clean one
      corrupt = 1'b1;
      start_req(1'b0, 16'h0056, 32'h11112222, t);
      check_txn(1'b0, 16'h0056, 32'h11112222, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);
      chk("verify_err", 64'(err), 64'(VERIFY));
      corrupt = 1'b0;
      start_req(1'b0, 16'h0057, 32'h33334444, t);
      check_txn(1'b0, 16'h0057, 32'h33334444, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);
      chk("verify_ok", 64'(err), 64'(0));

      // randomized traffic over a small address window
      for (int i = 0; i < 8; i++) begin
         r       = 1'($urandom_range(0, 1));
         a       = AW'($urandom_range(16'h0010, 16'h0017));
         d       = DW'($urandom);
         corrupt = ($urandom_range(0, 3) == 0);
         tr      = $urandom_range(0, 4);
         repeat (tr) @(negedge clk);
         start_req(r, a, d, t);
         check_txn(r, a, d, t, 1'b0, 1'b0, 1'b0, '0, '0, dc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
